exception_ctrl: RTL and testbench

//  Exception sequencer for the multicycle MIPS core. Watches the registered overflow flag

---
 rtl/exc_pkg.sv | 24 ++
 rtl/exc_wait_cnt.sv | 27 ++
 rtl/exception_ctrl.sv | 134 +++++++++++++
 tb/tb_exception_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception sequencer: FSM state encoding,
// cause codes and default vector byte addresses.
package exc_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSaveEpc = 3'd1,
    StReadVec = 3'd2,
    StLoadPc  = 3'd3,
    StDone    = 3'd4
  } exc_state_e;

  typedef enum logic [1:0] {
    ExcNone = 2'b00,
    ExcOpc  = 2'b01,
    ExcOvf  = 2'b10,
    ExcDiv0 = 2'b11
  } exc_cause_e;

  localparam logic [7:0] VecOpcodeDef = 8'd253;
  localparam logic [7:0] VecOvfDef    = 8'd254;
  localparam logic [7:0] VecDiv0Def   = 8'd255;

endpackage

// File: rtl/exc_wait_cnt.sv
// Loadable down-counter with enable and zero flag; times the vector read.
module exc_wait_cnt #(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/exception_ctrl.sv
// Exception sequencer for the multicycle core: save EPC, fetch the handler byte
// from the vector table, load PC. Main control stalls while exc_busy_o is high.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned MemLat    = 2,
  parameter logic [7:0]  VecOpcode = VecOpcodeDef,
  parameter logic [7:0]  VecOvf    = VecOvfDef,
  parameter logic [7:0]  VecDiv0   = VecDiv0Def
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       signed_arith_i,
  input  logic       overflow_flag_i,
  input  logic       opcode_inv_i,
  input  logic       div_zero_i,
  input  logic [7:0] mem_data_i,
  output logic       use_overflow_o,
  output logic       exc_busy_o,
  output logic       epc_write_o,
  output logic       mem_addr_sel_o,
  output logic [7:0] exc_addr_o,
  output logic       pc_write_o,
  output logic [7:0] exc_pc_byte_o,
  output logic [1:0] exc_cause_o,
  output logic       exc_done_o
);

  localparam int unsigned CntW = $clog2(MemLat + 1);

  exc_state_e state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] pc_byte_q, pc_byte_d;

  logic cnt_load, cnt_en, cnt_zero;
  logic busy, epc_wr, addr_sel, pc_wr, done;

  exc_wait_cnt #(
    .Width (CntW)
  ) u_wait_cnt (
    .clk_i      (clock_i),
    .rst_i      (reset_i),
    .load_i     (cnt_load),
    .load_val_i (CntW'(MemLat - 1)),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    addr_d    = addr_q;
    pc_byte_d = pc_byte_q;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    busy      = 1'b0;
    epc_wr    = 1'b0;
    addr_sel  = 1'b0;
    pc_wr     = 1'b0;
    done      = 1'b0;
    use_overflow_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        use_overflow_o = signed_arith_i;
        // Fixed priority; losing requests are dropped, not queued.
        if (opcode_inv_i) begin
          cause_d = ExcOpc;
          addr_d  = VecOpcode;
          state_d = StSaveEpc;
        end else if (overflow_flag_i) begin
          cause_d = ExcOvf;
          addr_d  = VecOvf;
          state_d = StSaveEpc;
        end else if (div_zero_i) begin
          cause_d = ExcDiv0;
          addr_d  = VecDiv0;
          state_d = StSaveEpc;
        end
      end
      StSaveEpc: begin
        epc_wr   = 1'b1;
        busy     = 1'b1;
        cnt_load = 1'b1;
        state_d  = StReadVec;
      end
      StReadVec: begin
        addr_sel = 1'b1;
        busy     = 1'b1;
        cnt_en   = 1'b1;
        if (cnt_zero) begin
          pc_byte_d = mem_data_i;
          state_d   = StLoadPc;
        end
      end
      StLoadPc: begin
        pc_wr   = 1'b1;
        busy    = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      cause_q   <= ExcNone;
      addr_q    <= '0;
      pc_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      addr_q    <= addr_d;
      pc_byte_q <= pc_byte_d;
    end
  end

  // Reset aborts at once: strobes of the cycle in which reset is seen never escape.
  assign exc_busy_o     = busy & ~reset_i;
  assign epc_write_o    = epc_wr & ~reset_i;
  assign mem_addr_sel_o = addr_sel & ~reset_i;
  assign pc_write_o     = pc_wr & ~reset_i;
  assign exc_done_o     = done & ~reset_i;
  assign exc_addr_o     = addr_q;
  assign exc_pc_byte_o  = pc_byte_q;
  assign exc_cause_o    = cause_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl; three instances (MemLat 2/1/4) share stimulus.
module tb_exception_ctrl;

  logic       clk;
  logic       reset;
  logic       signed_arith;
  logic       ovf_drv;
  logic       alu_ovf;
  logic       ovf_reg;
  logic       overflow_flag;
  logic       opcode_inv;
  logic       div_zero;
  logic [7:0] mem_data;

  logic       use_ovf, busy, epc, sel, pcw, done;
  logic [7:0] addr, pcbyte;
  logic [1:0] cause;

  logic       use_ovf1, busy1, epc1, sel1, pcw1, done1;
  logic [7:0] addr1, pcbyte1;
  logic [1:0] cause1;

  logic       use_ovf4, busy4, epc4, sel4, pcw4, done4;
  logic [7:0] addr4, pcbyte4;
  logic [1:0] cause4;

  int n_chk;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Overflow register model: enable gated by use_overflow of the main instance.
  always @(posedge clk) begin
    if (reset) ovf_reg <= 1'b0;
    else       ovf_reg <= use_ovf & alu_ovf;
  end

  assign overflow_flag = ovf_drv | ovf_reg;

  exception_ctrl #(.MemLat(2)) u_dut (
    .clock_i(clk), .reset_i(reset), .signed_arith_i(signed_arith),
    .overflow_flag_i(overflow_flag), .opcode_inv_i(opcode_inv), .div_zero_i(div_zero),
    .mem_data_i(mem_data), .use_overflow_o(use_ovf), .exc_busy_o(busy),
    .epc_write_o(epc), .mem_addr_sel_o(sel), .exc_addr_o(addr), .pc_write_o(pcw),
    .exc_pc_byte_o(pcbyte), .exc_cause_o(cause), .exc_done_o(done)
  );

  exception_ctrl #(.MemLat(1)) u_dut1 (
    .clock_i(clk), .reset_i(reset), .signed_arith_i(signed_arith),
    .overflow_flag_i(overflow_flag), .opcode_inv_i(opcode_inv), .div_zero_i(div_zero),
    .mem_data_i(mem_data), .use_overflow_o(use_ovf1), .exc_busy_o(busy1),
    .epc_write_o(epc1), .mem_addr_sel_o(sel1), .exc_addr_o(addr1), .pc_write_o(pcw1),
    .exc_pc_byte_o(pcbyte1), .exc_cause_o(cause1), .exc_done_o(done1)
  );

  exception_ctrl #(.MemLat(4)) u_dut4 (
    .clock_i(clk), .reset_i(reset), .signed_arith_i(signed_arith),
    .overflow_flag_i(overflow_flag), .opcode_inv_i(opcode_inv), .div_zero_i(div_zero),
    .mem_data_i(mem_data), .use_overflow_o(use_ovf4), .exc_busy_o(busy4),
    .epc_write_o(epc4), .mem_addr_sel_o(sel4), .exc_addr_o(addr4), .pc_write_o(pcw4),
    .exc_pc_byte_o(pcbyte4), .exc_cause_o(cause4), .exc_done_o(done4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Caller raises the request in cycle N; k counts cycles after N.
  task automatic run_seq(input string nm, input logic [1:0] ecause, input logic [7:0] eaddr,
                         input logic [7:0] mbyte, input bit pulse_div);
    mem_data = mbyte;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k == 1) begin
        opcode_inv = 1'b0;
        ovf_drv    = 1'b0;
        div_zero   = 1'b0;
        alu_ovf    = 1'b0;
      end
      if (pulse_div && k == 2) div_zero = 1'b1;
      if (pulse_div && k == 3) div_zero = 1'b0;
      #1;
      chk({nm, "_epc"},   epc,   (k == 1));
      chk({nm, "_sel"},   sel,   (k == 2 || k == 3));
      chk({nm, "_pcw"},   pcw,   (k == 4));
      chk({nm, "_done"},  done,  (k == 5));
      chk({nm, "_busy"},  busy,  (k >= 1 && k <= 4));
      chk({nm, "_cause"}, cause, ecause);
      chk({nm, "_addr"},  addr,  eaddr);
      chk({nm, "_pcw1"},  pcw1,  (k == 3));
      chk({nm, "_pcw4"},  pcw4,  (k == 6));
      if (k <= 5) chk({nm, "_useovf"}, use_ovf, 1'b0);
      if (k >= 4) chk({nm, "_pcbyte"}, pcbyte, mbyte);
      if (k >= 3) chk({nm, "_pcbyte1"}, pcbyte1, mbyte);
      if (k >= 6) chk({nm, "_pcbyte4"}, pcbyte4, mbyte);
    end
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    reset = 1'b1;
    signed_arith = 1'b0;
    ovf_drv = 1'b0;
    alu_ovf = 1'b0;
    opcode_inv = 1'b0;
    div_zero = 1'b0;
    mem_data = 8'h00;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    chk("rst_busy", busy, 1'b0);
    chk("rst_epc", epc, 1'b0);
    chk("rst_sel", sel, 1'b0);
    chk("rst_pcw", pcw, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_addr", addr, 8'h00);
    chk("rst_pcbyte", pcbyte, 8'h00);
    chk("rst_cause", cause, 2'b00);
    chk("rst_useovf", use_ovf, 1'b0);

    // Overflow exception
    ovf_drv = 1'b1;
    run_seq("ovf", 2'b10, 8'd254, 8'h40, 1'b0);

    // All three at once: opcode wins, one sequence only
    opcode_inv = 1'b1;
    ovf_drv    = 1'b1;
    div_zero   = 1'b1;
    run_seq("prio", 2'b01, 8'd253, 8'h5a, 1'b0);

    // div_zero pulse during READ_VEC is ignored
    ovf_drv = 1'b1;
    run_seq("ign", 2'b10, 8'd254, 8'h33, 1'b1);

    // Reset in the second READ_VEC cycle
    opcode_inv = 1'b1;
    mem_data   = 8'h77;
    cyc();
    opcode_inv = 1'b0;
    chk("mid_epc", epc, 1'b1);
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    chk("mid_sel", sel, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_pcw1", pcw1, 1'b0);
    cyc();
    reset = 1'b0;
    #1;
    chk("abrt_busy", busy, 1'b0);
    chk("abrt_epc", epc, 1'b0);
    chk("abrt_sel", sel, 1'b0);
    chk("abrt_pcw", pcw, 1'b0);
    chk("abrt_done", done, 1'b0);
    chk("abrt_addr", addr, 8'h00);
    chk("abrt_cause", cause, 2'b00);
    chk("abrt_pcbyte", pcbyte, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("abrt_nopcw", pcw, 1'b0);
      chk("abrt_noepc", epc, 1'b0);
    end
    div_zero = 1'b1;
    run_seq("div0", 2'b11, 8'd255, 8'h81, 1'b0);

    // Overflow register enable and self-clear
    signed_arith = 1'b1;
    alu_ovf      = 1'b1;
    #1;
    chk("uo_idle", use_ovf, 1'b1);
    cyc();
    chk("uo_flag", overflow_flag, 1'b1);
    run_seq("uo", 2'b10, 8'd254, 8'h99, 1'b0);
    chk("uo_reg_clr", ovf_reg, 1'b0);
    chk("uo_idle2", use_ovf, 1'b1);
    signed_arith = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
